ortho_ray_gen: RTL

- Orthographic camera ray generator that sits directly upstream of the sphere intersection stage.
- Walks the screen in raster order, one ray per pixel. Each ray's view_origin starts at a programmable base point and is stepped in x and y by a fixed-point pitch.
- view_direction is the constant normalised vector (0, 0, 1.0), so the downstream requirement that the direction be normalised always holds.
- Rays are emitted over a valid/ready handshake, with frame start/busy/done control.

---
 rtl/ortho_ray_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ortho_ray_gen.sv
// ortho_ray_gen: orthographic camera ray generator.
// Walks the screen in raster order and emits one ray per pixel over a
// valid/ready handshake. Ray origins start at a latched base point and are
// stepped in x and y by a fixed-point pitch. The direction is always (0,0,1.0).
// Optional build macro: ORTHO_RAY_GEN_FLIP_Y_EN. When defined, each row wrap
// subtracts the pitch from origin y, so screen y grows downward in world space.

package fixed_point;
   localparam int WIDTH     = 32;
   localparam int FRAC_BITS = 16;

   typedef logic signed [WIDTH-1:0] fixed_point_t;

   localparam fixed_point_t ONE = fixed_point_t'(1) <<< FRAC_BITS;

   // Wraparound add; overflow is reported separately.
   function automatic fixed_point_t fixed_point_add(input fixed_point_t a, input fixed_point_t b);
      return a + b;
   endfunction

   // Signed overflow: operands share a sign and the result sign differs.
   function automatic logic fixed_point_add_ovf(input fixed_point_t a, input fixed_point_t b);
      fixed_point_t s;
      s = a + b;
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   // Wraparound subtract; overflow is reported separately.
   function automatic fixed_point_t fixed_point_sub(input fixed_point_t a, input fixed_point_t b);
      return a - b;
   endfunction

   // Signed overflow: operand signs differ and the result sign differs from a.
   function automatic logic fixed_point_sub_ovf(input fixed_point_t a, input fixed_point_t b);
      fixed_point_t s;
      s = a - b;
      return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction
endpackage

package vector;
   typedef struct packed {
      fixed_point::fixed_point_t x;
      fixed_point::fixed_point_t y;
      fixed_point::fixed_point_t z;
   } vector_t;
endpackage

// Handshake: a ray transfers on any rising edge where ray_valid && ray_ready.
// While ray_valid is high and ray_ready is low, every ray output holds stable.
// ray_valid never drops without a transfer except on reset.
module ortho_ray_gen #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  vector::vector_t              origin_base,
   input  fixed_point::fixed_point_t    step,
   output logic                         ray_valid,
   input  logic                         ray_ready,
   output vector::vector_t              view_origin,
   output vector::vector_t              view_direction,
   output logic [$clog2(H_RES)-1:0]     pixel_x,
   output logic [$clog2(V_RES)-1:0]     pixel_y,
   output logic                         ray_last,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic [1:0]                   state_dbg
);

   localparam int XW = $clog2(H_RES);
   localparam int YW = $clog2(V_RES);

   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EMIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                state;
   fixed_point::fixed_point_t base_x_q;
   fixed_point::fixed_point_t step_q;

   fixed_point::fixed_point_t x_next;
   fixed_point::fixed_point_t y_next;
   logic                      x_ovf;
   logic                      y_ovf;
   logic                      xfer;
   logic                      at_row_end;

   // Status outputs decode straight from state so they clear with reset.
   assign ray_valid  = (state == ST_EMIT);
   assign busy       = (state == ST_EMIT);
   assign done       = (state == ST_DONE);
   assign state_dbg  = state;
   assign ray_last   = ray_valid && (pixel_x == X_LAST) && (pixel_y == Y_LAST);
   assign xfer       = ray_valid && ray_ready;
   assign at_row_end = (pixel_x == X_LAST);

   assign view_direction = '{x: '0, y: '0, z: fixed_point::ONE};

   // Candidate origin updates and their overflow flags for the next advance.
   always_comb begin
      x_next = fixed_point::fixed_point_add(view_origin.x, step_q);
      x_ovf  = fixed_point::fixed_point_add_ovf(view_origin.x, step_q);
`ifdef ORTHO_RAY_GEN_FLIP_Y_EN
      y_next = fixed_point::fixed_point_sub(view_origin.y, step_q);
      y_ovf  = fixed_point::fixed_point_sub_ovf(view_origin.y, step_q);
`else
      y_next = fixed_point::fixed_point_add(view_origin.y, step_q);
      y_ovf  = fixed_point::fixed_point_add_ovf(view_origin.y, step_q);
`endif
   end

   // Frame FSM plus raster counters and origin stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         base_x_q    <= '0;
         step_q      <= '0;
         view_origin <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_x_q    <= origin_base.x;
                  step_q      <= step;
                  view_origin <= origin_base;
                  pixel_x     <= '0;
                  pixel_y     <= '0;
                  overflow    <= 1'b0;
                  state       <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (xfer) begin
                  if (ray_last) begin
                     // Final ray: counters stay put, the frame closes.
                     state <= ST_DONE;
                  end else if (!at_row_end) begin
                     pixel_x       <= pixel_x + X_ONE;
                     view_origin.x <= x_next;
                     if (x_ovf) overflow <= 1'b1;
                  end else begin
                     // Row wrap: x reloads from the latched base, y steps.
                     pixel_x       <= '0;
                     pixel_y       <= pixel_y + Y_ONE;
                     view_origin.x <= base_x_q;
                     view_origin.y <= y_next;
                     if (y_ovf) overflow <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
